// File: rtl/hpdcache_rr_arbiter.sv
// Round-robin arbiter with a zero-latency grant that locks onto the selected
// requester while downstream stalls, so the presented request never changes mid-handshake.
module hpdcache_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned Log2N = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_valid_i,
  output logic [N-1:0]     req_ready_o,
  output logic             arb_valid_o,
  input  logic             arb_ready_i,
  output logic [N-1:0]     arb_gnt_o,
  output logic [Log2N-1:0] arb_idx_o
);

  localparam logic [0:0] STATE_IDLE   = 1'b0;
  localparam logic [0:0] STATE_LOCKED = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [Log2N-1:0] last_q, last_d;
  logic [Log2N-1:0] lock_q, lock_d;

  logic             sel_found;
  logic [Log2N-1:0] sel;
  logic [Log2N-1:0] gnt_idx;
  logic             locked;

  // Returns {found, index} of the first valid requester after 'last', wrapping.
  function automatic logic [Log2N:0] rr_pick(input logic [N-1:0]     valid,
                                             input logic [Log2N-1:0] last);
    logic [Log2N:0] res;
    int unsigned    cand;
    res = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last) + k) % N;
      if (!res[Log2N] && valid[Log2N'(cand)]) begin
        res = {1'b1, Log2N'(cand)};
      end
    end
    return res;
  endfunction

  always_comb begin
    {sel_found, sel} = rr_pick(req_valid_i, last_q);
    locked  = (state_q == STATE_LOCKED);
    gnt_idx = locked ? lock_q : sel;

    // Outputs are forced quiet while reset is applied so a held grant is dropped silently.
    arb_valid_o = !rst_i && (locked || sel_found);
    arb_gnt_o   = arb_valid_o ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    arb_idx_o   = arb_valid_o ? gnt_idx : '0;
    req_ready_o = arb_gnt_o & {N{arb_ready_i}};
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    lock_d  = lock_q;
    if (arb_valid_o) begin
      if (arb_ready_i) begin
        last_d  = gnt_idx;
        state_d = STATE_IDLE;
      end else if (!locked) begin
        lock_d  = sel;
        state_d = STATE_LOCKED;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= STATE_IDLE;
      last_q  <= Log2N'(N - 1);
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
    end
  end

`ifndef HPDCACHE_ASSERT_OFF
  gnt_onehot_a: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(arb_gnt_o));
  ready_onehot_a: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(req_ready_o));
  idx_match_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (arb_gnt_o == '0) ? (arb_idx_o == '0) : arb_gnt_o[arb_idx_o]);
  // A requester holding a locked grant must keep its request up until accepted.
  locked_req_held_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == STATE_LOCKED) |-> req_valid_i[lock_q]);
`endif

endmodule

// File: tb/tb_hpdcache_rr_arbiter.sv
// Bench for hpdcache_rr_arbiter: directed scenarios on an N=4 instance and a
// long randomized run on an N=3 instance, both against a rotating-priority-list model.
module tb_hpdcache_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rs4 = 1'b1, r4 = 1'b0, val4;
  logic [3:0] v4 = '0, rdy4, gnt4;
  logic [1:0] idx4;

  logic       rs3 = 1'b1, r3 = 1'b0, val3;
  logic [2:0] v3 = '0, rdy3, gnt3;
  logic [1:0] idx3;

  int vectors = 0;
  int miscompares = 0;

  hpdcache_rr_arbiter #(.N(4)) dut4 (
    .clk_i(clk), .rst_i(rs4), .req_valid_i(v4), .req_ready_o(rdy4),
    .arb_valid_o(val4), .arb_ready_i(r4), .arb_gnt_o(gnt4), .arb_idx_o(idx4));

  hpdcache_rr_arbiter #(.N(3)) dut3 (
    .clk_i(clk), .rst_i(rs3), .req_valid_i(v3), .req_ready_o(rdy3),
    .arb_valid_o(val3), .arb_ready_i(r3), .arb_gnt_o(gnt3), .arb_idx_o(idx3));

  // Model: priority list per instance (front = highest priority), plus a held grant.
  int ord  [2][4];
  int nreq [2] = '{4, 3};
  bit lk   [2];
  int lki  [2];

  function automatic int pick(int inst, logic [3:0] v);
    if (lk[inst]) return lki[inst];
    for (int k = 0; k < nreq[inst]; k++)
      if (v[ord[inst][k]]) return ord[inst][k];
    return -1;
  endfunction

  function automatic logic [10:0] model_out(int inst, logic [3:0] v, logic r, logic rs);
    int e;
    logic vld;
    logic [3:0] g, rd;
    logic [1:0] ix;
    e   = rs ? -1 : pick(inst, v);
    vld = (e >= 0);
    g   = vld ? 4'(1 << e) : 4'b0;
    ix  = vld ? 2'(e) : 2'b0;
    rd  = r ? g : 4'b0;
    return {vld, g, ix, rd};
  endfunction

  function automatic void model_step(int inst, logic [3:0] v, logic r, logic rs);
    int e, n, tmp;
    n = nreq[inst];
    if (rs) begin
      for (int k = 0; k < n; k++) ord[inst][k] = k;
      lk[inst] = 0;
      lki[inst] = 0;
      return;
    end
    e = pick(inst, v);
    if (e < 0) return;
    if (r) begin
      // Served requester drops to the back, its successors keep cyclic order.
      while (ord[inst][n-1] != e) begin
        tmp = ord[inst][0];
        for (int k = 0; k < n - 1; k++) ord[inst][k] = ord[inst][k+1];
        ord[inst][n-1] = tmp;
      end
      lk[inst] = 0;
    end else begin
      lk[inst]  = 1;
      lki[inst] = e;
    end
  endfunction

  task automatic apply4(logic [3:0] v, logic r, logic rs);
    @(posedge clk); #1;
    v4 = v; r4 = r; rs4 = rs;
    @(negedge clk);
  endtask

  task automatic apply3(logic [2:0] v, logic r, logic rs);
    @(posedge clk); #1;
    v3 = v; r3 = r; rs3 = rs;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [10:0] e4, e3;
    for (int c = 0; c < 2; c++) begin
      apply4(4'b1111, 1'b1, 1'b1);
      apply3(3'b111, 1'b1, 1'b1);
      e4 = model_out(0, v4, r4, rs4);
      e3 = model_out(1, {1'b0, v3}, r3, rs3);
      vectors += 2;
      if ({val4, gnt4, idx4, rdy4} !== e4) begin
        miscompares++;
        $display("FAIL reset4 cyc %0d: got %b expected %b", c, {val4, gnt4, idx4, rdy4}, e4);
      end
      if ({val3, 1'b0, gnt3, idx3, 1'b0, rdy3} !== e3) begin
        miscompares++;
        $display("FAIL reset3 cyc %0d: got %b expected %b", c, {val3, 1'b0, gnt3, idx3, 1'b0, rdy3}, e3);
      end
      model_step(0, v4, r4, rs4);
      model_step(1, {1'b0, v3}, r3, rs3);
    end
    v3 = '0; r3 = 1'b0; rs3 = 1'b0;
  endtask

  task automatic test_rotation;
    int want [5] = '{0, 1, 2, 3, 0};
    logic [10:0] e;
    for (int c = 0; c < 5; c++) begin
      apply4(4'b1111, 1'b1, 1'b0);
      e = model_out(0, v4, r4, rs4);
      vectors += 2;
      if ({val4, gnt4, idx4, rdy4} !== e) begin
        miscompares++;
        $display("FAIL rotation cyc %0d: got %b expected %b", c, {val4, gnt4, idx4, rdy4}, e);
      end
      if (idx4 !== 2'(want[c]) || rdy4 !== 4'(1 << want[c])) begin
        miscompares++;
        $display("FAIL rotation_seq cyc %0d: idx %0d ready %b, expected idx %0d", c, idx4, rdy4, want[c]);
      end
      model_step(0, v4, r4, rs4);
    end
  endtask

  task automatic test_wrap;
    logic [3:0] vs [2] = '{4'b0010, 4'b0011};
    logic [10:0] e;
    for (int c = 0; c < 2; c++) begin
      apply4(vs[c], 1'b1, 1'b0);
      e = model_out(0, v4, r4, rs4);
      vectors++;
      if ({val4, gnt4, idx4, rdy4} !== e) begin
        miscompares++;
        $display("FAIL wrap cyc %0d: got %b expected %b", c, {val4, gnt4, idx4, rdy4}, e);
      end
      model_step(0, v4, r4, rs4);
    end
    vectors++;
    if (idx4 !== 2'd0) begin
      miscompares++;
      $display("FAIL wrap_idx: got %0d expected 0", idx4);
    end
  endtask

  task automatic test_idle;
    apply4(4'b0000, 1'b1, 1'b0);
    vectors++;
    if ({val4, gnt4, idx4, rdy4} !== 11'b0) begin
      miscompares++;
      $display("FAIL idle: got %b expected %b", {val4, gnt4, idx4, rdy4}, 11'b0);
    end
    model_step(0, v4, r4, rs4);
  endtask

  task automatic test_lock;
    logic [3:0] vs [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0101, 4'b0101, 4'b0101};
    logic       rd [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int         wi [6] = '{2, 2, 2, 2, 2, 0};
    logic [10:0] e;
    for (int c = 0; c < 6; c++) begin
      apply4(vs[c], rd[c], 1'b0);
      e = model_out(0, v4, r4, rs4);
      vectors += 2;
      if ({val4, gnt4, idx4, rdy4} !== e) begin
        miscompares++;
        $display("FAIL lock cyc %0d: got %b expected %b", c, {val4, gnt4, idx4, rdy4}, e);
      end
      if (idx4 !== 2'(wi[c]) || rdy4 !== (rd[c] ? 4'(1 << wi[c]) : 4'b0)) begin
        miscompares++;
        $display("FAIL lock_idx cyc %0d: idx %0d ready %b, expected idx %0d", c, idx4, rdy4, wi[c]);
      end
      model_step(0, v4, r4, rs4);
    end
  endtask

  task automatic test_reset_locked;
    logic [3:0] vs [5] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1001};
    logic       rd [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       rr [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [10:0] e;
    for (int c = 0; c < 5; c++) begin
      apply4(vs[c], rd[c], rr[c]);
      e = model_out(0, v4, r4, rs4);
      vectors++;
      if ({val4, gnt4, idx4, rdy4} !== e) begin
        miscompares++;
        $display("FAIL reset_locked cyc %0d: got %b expected %b", c, {val4, gnt4, idx4, rdy4}, e);
      end
      if (c == 2) begin
        vectors++;
        if (rdy4 !== 4'b0) begin
          miscompares++;
          $display("FAIL reset_no_pulse: ready %b expected 0000", rdy4);
        end
      end
      if (c == 3) begin
        vectors++;
        if (idx4 !== 2'd3 || rdy4 !== 4'b1000) begin
          miscompares++;
          $display("FAIL post_reset_idle: idx %0d ready %b expected idx 3 ready 1000", idx4, rdy4);
        end
      end
      model_step(0, v4, r4, rs4);
    end
    apply4(4'b0000, 1'b0, 1'b0);
    model_step(0, v4, r4, rs4);
  endtask

  task automatic test_random;
    logic [10:0] e;
    logic [2:0]  v;
    logic        r;
    logic        prev_stall = 1'b0;
    logic [1:0]  prev_idx = '0;
    int          waitc [3] = '{0, 0, 0};
    logic        hs;
    for (int c = 0; c < 10000; c++) begin
      v = 3'($urandom_range(0, 7));
      r = ($urandom_range(0, 3) != 0);
      if (prev_stall) v[prev_idx] = 1'b1;
      apply3(v, r, 1'b0);
      e = model_out(1, {1'b0, v3}, r3, rs3);
      vectors++;
      if ({val3, 1'b0, gnt3, idx3, 1'b0, rdy3} !== e) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %b expected %b", c, {val3, 1'b0, gnt3, idx3, 1'b0, rdy3}, e);
      end
      if (prev_stall) begin
        vectors++;
        if (!val3 || idx3 !== prev_idx) begin
          miscompares++;
          $display("FAIL lock_hold cyc %0d: valid %b idx %0d expected idx %0d", c, val3, idx3, prev_idx);
        end
      end
      hs = val3 && r3;
      for (int i = 0; i < 3; i++) begin
        if (!v3[i] || (hs && idx3 == 2'(i))) waitc[i] = 0;
        else if (hs) begin
          waitc[i]++;
          vectors++;
          if (waitc[i] >= 3) begin
            miscompares++;
            $display("FAIL fairness cyc %0d: req %0d waited %0d handshakes, limit 2", c, i, waitc[i]);
          end
        end
      end
      prev_stall = val3 && !r3;
      prev_idx   = idx3;
      model_step(1, {1'b0, v3}, r3, rs3);
    end
    apply3(3'b000, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_rotation;
    test_wrap;
    test_idle;
    test_lock;
    test_reset_locked;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
